// File: rtl/mgmt_poll_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mgmt_poll_arbiter_if
// Purpose  : Management request port of the 10G MAC management block.
//            The request fields and strobe come from the arbiter. Read data
//            and the idle flag come from the management block.
// Ports    : mgmt_opcode/addr/wr_data/miim_sel/req  arbiter -> management
//            mgmt_rd_data, mgmt_miim_rdy             management -> arbiter
// Modports : master = arbiter side, slave = management block side
// Revision : 1.0  initial release
// ============================================================================
interface mgmt_poll_arbiter_if;
    logic [1:0]  mgmt_opcode;
    logic [9:0]  mgmt_addr;
    logic [31:0] mgmt_wr_data;
    logic        mgmt_miim_sel;
    logic        mgmt_req;
    logic [31:0] mgmt_rd_data;
    logic        mgmt_miim_rdy;

    modport master (
        output mgmt_opcode, mgmt_addr, mgmt_wr_data, mgmt_miim_sel, mgmt_req,
        input  mgmt_rd_data, mgmt_miim_rdy
    );

    modport slave (
        input  mgmt_opcode, mgmt_addr, mgmt_wr_data, mgmt_miim_sel, mgmt_req,
        output mgmt_rd_data, mgmt_miim_rdy
    );
endinterface
`default_nettype wire

// File: rtl/mgmt_poll_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mgmt_poll_arbiter
// Purpose  : Shares the management request port between a host requester
//            and a periodic PHY-status poller. It runs one transaction at a
//            time, waits for register or MDIO completion, returns read data
//            to the winner and guards each transaction with a timeout.
// Ports    : mgmt_clk, reset                    clock, sync active-high reset
//            host_req/opcode/addr/wr_data/miim_sel  host request (level)
//            host_ack/err/rd_data                   host completion
//            poll_en, poll_status/valid/timeout     periodic poller
//            mgmt (mgmt_poll_arbiter_if.master)     management request port
// Revision : 1.0  initial release
// ============================================================================
module mgmt_poll_arbiter #(
    parameter int         POLL_PERIOD = 100000,
    parameter logic [9:0] POLL_ADDR   = 10'h021,
    parameter int         TIMEOUT     = 4096
) (
    input  logic                 mgmt_clk,
    input  logic                 reset,
    input  logic                 host_req,
    input  logic [1:0]           host_opcode,
    input  logic [9:0]           host_addr,
    input  logic [31:0]          host_wr_data,
    input  logic                 host_miim_sel,
    output logic                 host_ack,
    output logic                 host_err,
    output logic [31:0]          host_rd_data,
    input  logic                 poll_en,
    output logic [15:0]          poll_status,
    output logic                 poll_valid,
    output logic                 poll_timeout,
    mgmt_poll_arbiter_if.master  mgmt
);

    localparam int                  c_tmr_w      = $clog2(POLL_PERIOD);
    localparam int                  c_to_w       = $clog2(TIMEOUT);
    localparam logic [c_tmr_w-1:0]  c_tmr_reload = c_tmr_w'(POLL_PERIOD - 1);
    localparam logic [c_to_w-1:0]   c_to_last    = c_to_w'(TIMEOUT - 1);
    // The counter is 0 in ISSUE, so WAIT cycles 1 and 2 are the MDIO blanking window.
    localparam logic [c_to_w-1:0]   c_blank_end  = c_to_w'(3);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_tmr_w-1:0] r_timer;
    logic               r_poll_pending;
    logic               r_last_host;
    logic               r_win_host;
    logic [c_to_w-1:0]  r_cnt;

    logic               r_host_ack;
    logic               r_host_err;
    logic [31:0]        r_host_rd_data;
    logic [15:0]        r_poll_status;
    logic               r_poll_valid;
    logic               r_poll_timeout;
    logic [1:0]         r_mgmt_opcode;
    logic [9:0]         r_mgmt_addr;
    logic [31:0]        r_mgmt_wr_data;
    logic               r_mgmt_miim_sel;
    logic               r_mgmt_req;

    logic               w_grant;
    logic               w_pick_host;
    logic               w_in_wait;
    logic               w_complete;
    logic               w_timeout;

    assign w_grant     = (r_state == c_st_idle) && mgmt.mgmt_miim_rdy && (host_req || r_poll_pending);
    // On a tie the host wins unless it was the last one served.
    assign w_pick_host = host_req && (!r_poll_pending || !r_last_host);
    assign w_in_wait   = (r_state == c_st_wait);
    // Register accesses have a fixed latency and finish in the first WAIT cycle.
    assign w_complete  = w_in_wait && (!r_mgmt_miim_sel ||
                                       ((r_cnt >= c_blank_end) && mgmt.mgmt_miim_rdy));
    assign w_timeout   = w_in_wait && !w_complete && (r_cnt == c_to_last);

    always_ff @(posedge mgmt_clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:  if (w_grant) w_next_state = c_st_issue;
            c_st_issue: w_next_state = c_st_wait;
            c_st_wait:  if (w_complete || w_timeout) w_next_state = c_st_done;
            default:    w_next_state = c_st_idle;
        endcase
    end

    // Poll timer runs independently of transactions; an expiry in the same
    // cycle as a poll grant re-arms the pending flag.
    always_ff @(posedge mgmt_clk) begin
        if (reset || !poll_en) begin
            r_timer        <= c_tmr_reload;
            r_poll_pending <= 1'b0;
        end else begin
            if (w_grant && !w_pick_host) begin
                r_poll_pending <= 1'b0;
            end
            if (r_timer == '0) begin
                r_timer        <= c_tmr_reload;
                r_poll_pending <= 1'b1;
            end else begin
                r_timer <= r_timer - c_tmr_w'(1);
            end
        end
    end

    always_ff @(posedge mgmt_clk) begin
        if (reset) begin
            r_last_host     <= 1'b0;
            r_win_host      <= 1'b0;
            r_cnt           <= '0;
            r_host_ack      <= 1'b0;
            r_host_err      <= 1'b0;
            r_host_rd_data  <= '0;
            r_poll_status   <= '0;
            r_poll_valid    <= 1'b0;
            r_poll_timeout  <= 1'b0;
            r_mgmt_opcode   <= '0;
            r_mgmt_addr     <= '0;
            r_mgmt_wr_data  <= '0;
            r_mgmt_miim_sel <= 1'b0;
            r_mgmt_req      <= 1'b0;
        end else begin
            r_mgmt_req <= w_grant;
            if (w_grant) begin
                r_win_host  <= w_pick_host;
                r_last_host <= w_pick_host;
                if (w_pick_host) begin
                    r_mgmt_opcode   <= host_opcode;
                    r_mgmt_addr     <= host_addr;
                    r_mgmt_wr_data  <= host_wr_data;
                    r_mgmt_miim_sel <= host_miim_sel;
                end else begin
                    r_mgmt_opcode   <= 2'b10;
                    r_mgmt_addr     <= POLL_ADDR;
                    r_mgmt_wr_data  <= '0;
                    r_mgmt_miim_sel <= 1'b1;
                end
            end

            // Cycles since ISSUE; zero whenever no transaction is in flight.
            if ((r_state == c_st_issue) || w_in_wait) begin
                r_cnt <= r_cnt + c_to_w'(1);
            end else begin
                r_cnt <= '0;
            end

            // Results are registered on the WAIT->DONE edge so they show during DONE.
            r_host_ack   <= (w_complete || w_timeout) && r_win_host;
            r_host_err   <= w_timeout && r_win_host;
            r_poll_valid <= w_complete && !r_win_host;
            if ((w_complete || w_timeout) && r_win_host) begin
                r_host_rd_data <= w_timeout ? 32'hFFFF_FFFF : mgmt.mgmt_rd_data;
            end
            if (w_complete && !r_win_host) begin
                r_poll_status <= mgmt.mgmt_rd_data[15:0];
            end
            if (w_timeout && !r_win_host) begin
                r_poll_timeout <= 1'b1;
            end
        end
    end

    assign host_ack           = r_host_ack;
    assign host_err           = r_host_err;
    assign host_rd_data       = r_host_rd_data;
    assign poll_status        = r_poll_status;
    assign poll_valid         = r_poll_valid;
    assign poll_timeout       = r_poll_timeout;
    assign mgmt.mgmt_opcode   = r_mgmt_opcode;
    assign mgmt.mgmt_addr     = r_mgmt_addr;
    assign mgmt.mgmt_wr_data  = r_mgmt_wr_data;
    assign mgmt.mgmt_miim_sel = r_mgmt_miim_sel;
    assign mgmt.mgmt_req      = r_mgmt_req;

endmodule
`default_nettype wire

// File: tb/tb_mgmt_poll_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mgmt_poll_arbiter
// Purpose  : Self-checking bench for mgmt_poll_arbiter. A small management
//            block model answers MDIO requests with a programmable latency;
//            expected grants and results are queued when stimulus is driven
//            and compared when the DUT produces them.
// Revision : 1.0  initial release
// ============================================================================
module tb_mgmt_poll_arbiter;

    typedef struct packed {
        logic [1:0]  op;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic        miim;
    } grant_t;

    localparam grant_t c_poll_g = {2'b10, 10'h021, 32'd0, 1'b1};

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        host_req;
    logic [1:0]  host_opcode;
    logic [9:0]  host_addr;
    logic [31:0] host_wr_data;
    logic        host_miim_sel;
    logic        host_ack;
    logic        host_err;
    logic [31:0] host_rd_data;
    logic        poll_en;
    logic [15:0] poll_status;
    logic        poll_valid;
    logic        poll_timeout;

    logic        resp_rdy;
    logic        resp_busy;
    logic        force_busy;
    int          resp_lat;
    logic [31:0] reg_data;
    logic [31:0] mdio_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    grant_t      exp_grant[$];
    logic [32:0] exp_host[$];
    logic [15:0] exp_poll[$];

    mgmt_poll_arbiter_if mif ();

    assign mif.mgmt_miim_rdy = resp_rdy & ~force_busy;
    assign mif.mgmt_rd_data  = mif.mgmt_miim_sel ? mdio_data : reg_data;

    mgmt_poll_arbiter #(
        .POLL_PERIOD (16),
        .POLL_ADDR   (10'h021),
        .TIMEOUT     (64)
    ) dut (
        .mgmt_clk      (clk),
        .reset         (rst),
        .host_req      (host_req),
        .host_opcode   (host_opcode),
        .host_addr     (host_addr),
        .host_wr_data  (host_wr_data),
        .host_miim_sel (host_miim_sel),
        .host_ack      (host_ack),
        .host_err      (host_err),
        .host_rd_data  (host_rd_data),
        .poll_en       (poll_en),
        .poll_status   (poll_status),
        .poll_valid    (poll_valid),
        .poll_timeout  (poll_timeout),
        .mgmt          (mif)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {host_ack, host_err, poll_valid, poll_timeout, mif.mgmt_req,
                              mif.mgmt_miim_sel, poll_status, mif.mgmt_opcode, mif.mgmt_addr}, 64'd0);
        check({tag, "_rd"}, host_rd_data, 64'd0);
        check({tag, "_wd"}, mif.mgmt_wr_data, 64'd0);
    endtask

    // Host transaction: raise host_req in the current (IDLE) cycle, drop it
    // once the request is issued, return issue and ack cycle numbers.
    task automatic host_txn(input logic [1:0] op, input logic [9:0] a, input logic [31:0] wd,
                            input logic ms, input logic [32:0] res,
                            output int n0, output int t_req, output int t_ack);
        exp_grant.push_back({op, a, wd, ms});
        exp_host.push_back(res);
        host_opcode   = op;
        host_addr     = a;
        host_wr_data  = wd;
        host_miim_sel = ms;
        host_req      = 1'b1;
        n0 = cyc;
        for (int i = 0; i < 50 && !mif.mgmt_req; i++) tick();
        t_req = cyc;
        check("host_req_seen", mif.mgmt_req, 1'b1);
        host_req = 1'b0;
        for (int i = 0; i < 200 && !host_ack; i++) tick();
        t_ack = cyc;
        check("host_ack_seen", host_ack, 1'b1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Management block model: MDIO goes busy the cycle after a request and
    // becomes ready again resp_lat cycles after the request.
    initial begin
        resp_rdy  = 1'b1;
        resp_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (mif.mgmt_req && mif.mgmt_miim_sel) begin
                resp_busy = 1'b1;
                @(posedge clk);
                #1 resp_rdy = 1'b0;
                repeat (resp_lat - 1) @(posedge clk);
                #1 resp_rdy = 1'b1;
                resp_busy = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        logic        prev_req;
        grant_t      g;
        logic [32:0] e;
        logic [15:0] p;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (mif.mgmt_req) begin
                check("req_single_pulse", prev_req, 1'b0);
                if (exp_grant.size() == 0) begin
                    check("grant_unexpected", 1'b1, 1'b0);
                end else begin
                    g = exp_grant.pop_front();
                    check("grant_fields", {mif.mgmt_opcode, mif.mgmt_addr, mif.mgmt_wr_data,
                                           mif.mgmt_miim_sel}, g);
                end
            end
            prev_req = mif.mgmt_req;
            if (host_ack) begin
                if (exp_host.size() == 0) begin
                    check("host_ack_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_host.pop_front();
                    check("host_result", {host_err, host_rd_data}, e);
                end
            end
            if (poll_valid) begin
                if (exp_poll.size() == 0) begin
                    check("poll_valid_unexpected", 1'b1, 1'b0);
                end else begin
                    p = exp_poll.pop_front();
                    check("poll_status", poll_status, p);
                end
            end
        end
    end

    initial begin
        int   n0, tr, ta, t1, t2, seen, nreq, nack;
        logic flag;
        rst = 1'b1; host_req = 1'b0; host_opcode = 2'b00; host_addr = '0;
        host_wr_data = '0; host_miim_sel = 1'b0; poll_en = 1'b0;
        force_busy = 1'b0; resp_lat = 5; reg_data = '0; mdio_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_all_zero("reset");

        // Host register read.
        reg_data = 32'h1234_5678;
        host_txn(2'b10, 10'h240, 32'd0, 1'b0, {1'b0, 32'h1234_5678}, n0, tr, ta);
        check("reg_req_lat", tr - n0, 1);
        check("reg_ack_lat", ta - n0, 3);
        tick();

        // Host register write.
        reg_data = 32'h0BAD_F00D;
        host_txn(2'b01, 10'h3FF, 32'hDEAD_BEEF, 1'b0, {1'b0, 32'h0BAD_F00D}, n0, tr, ta);
        tick();

        // Host MDIO read, ready 5 cycles after the request.
        mdio_data = 32'h0000_5A5A; resp_lat = 5;
        host_txn(2'b10, 10'h0E3, 32'd0, 1'b1, {1'b0, 32'h0000_5A5A}, n0, tr, ta);
        check("mdio_ack_lat", ta - n0, 7);
        tick();

        // MDIO ready back almost immediately: blanking holds completion off.
        mdio_data = 32'h0000_1C1C; resp_lat = 1;
        host_txn(2'b10, 10'h0E4, 32'd0, 1'b1, {1'b0, 32'h0000_1C1C}, n0, tr, ta);
        check("blank_ack_lat", ta - n0, 5);
        tick();

        // Busy gating.
        reg_data = 32'h1111_2222;
        exp_grant.push_back({2'b10, 10'h111, 32'd0, 1'b0});
        exp_host.push_back({1'b0, 32'h1111_2222});
        force_busy = 1'b1;
        host_opcode = 2'b10; host_addr = 10'h111; host_wr_data = '0; host_miim_sel = 1'b0;
        host_req = 1'b1;
        flag = 1'b0;
        repeat (6) begin
            tick();
            flag = flag | mif.mgmt_req;
        end
        check("busy_no_req", flag, 1'b0);
        force_busy = 1'b0;
        tick();
        check("busy_grant_lat", mif.mgmt_req, 1'b1);
        host_req = 1'b0;
        for (int i = 0; i < 20 && !host_ack; i++) tick();
        check("busy_ack", host_ack, 1'b1);
        tick();

        // Host MDIO timeout.
        resp_lat = 80;
        host_txn(2'b10, 10'h0E5, 32'd0, 1'b1, {1'b1, 32'hFFFF_FFFF}, n0, tr, ta);
        check("host_to_lat", ta - tr, 64);
        for (int i = 0; i < 200 && resp_busy; i++) tick();
        tick();

        // Poll success, two back-to-back polls.
        mdio_data = 32'hCAFE_7809; resp_lat = 40;
        exp_grant.push_back(c_poll_g); exp_grant.push_back(c_poll_g);
        exp_poll.push_back(16'h7809);  exp_poll.push_back(16'h7809);
        poll_en = 1'b1;
        seen = 0; t1 = 0; t2 = 0;
        for (int i = 0; i < 300 && seen < 2; i++) begin
            tick();
            if (mif.mgmt_req) begin
                seen++;
                if (seen == 1) t1 = cyc;
                else begin
                    t2 = cyc;
                    poll_en = 1'b0;
                end
            end
        end
        check("poll_grants_seen", seen, 2);
        check("poll_gap", t2 - t1, 43);
        for (int i = 0; i < 200 && (exp_poll.size() != 0 || resp_busy); i++) tick();
        check("poll_status_final", {poll_timeout, poll_status}, {1'b0, 16'h7809});
        tick();

        // Contention: host, poll, host.
        mdio_data = 32'hABCD_1357; resp_lat = 3; reg_data = 32'h2468_ACE0;
        force_busy = 1'b1; poll_en = 1'b1;
        repeat (20) tick();
        exp_grant.push_back({2'b10, 10'h240, 32'd0, 1'b0});
        exp_grant.push_back(c_poll_g);
        exp_grant.push_back({2'b10, 10'h240, 32'd0, 1'b0});
        exp_host.push_back({1'b0, 32'h2468_ACE0});
        exp_host.push_back({1'b0, 32'h2468_ACE0});
        exp_poll.push_back(16'h1357);
        host_opcode = 2'b10; host_addr = 10'h240; host_wr_data = '0; host_miim_sel = 1'b0;
        host_req = 1'b1;
        force_busy = 1'b0;
        nreq = 0; nack = 0;
        for (int i = 0; i < 100 && nack < 2; i++) begin
            tick();
            if (mif.mgmt_req) begin
                nreq++;
                if (nreq == 3) poll_en = 1'b0;
            end
            if (host_ack) begin
                nack++;
                if (nack == 2) host_req = 1'b0;
            end
        end
        check("cont_acks", nack, 2);
        check("cont_reqs", nreq, 3);
        for (int i = 0; i < 50 && (exp_poll.size() != 0 || exp_grant.size() != 0 || resp_busy); i++) tick();
        tick();

        // Poll timeout: sticky flag, status untouched.
        resp_lat = 80;
        exp_grant.push_back(c_poll_g);
        poll_en = 1'b1;
        for (int i = 0; i < 60 && !mif.mgmt_req; i++) tick();
        tr = cyc;
        check("poll_to_req_seen", mif.mgmt_req, 1'b1);
        poll_en = 1'b0;
        for (int i = 0; i < 100 && !poll_timeout; i++) tick();
        check("poll_to_lat", cyc - tr, 64);
        check("poll_to_status", {poll_timeout, poll_status}, {1'b1, 16'h1357});
        for (int i = 0; i < 200 && resp_busy; i++) tick();
        repeat (3) tick();
        check("poll_to_sticky", poll_timeout, 1'b1);

        // Reset in the middle of an MDIO WAIT.
        resp_lat = 20;
        exp_grant.push_back({2'b10, 10'h0AA, 32'd0, 1'b1});
        host_opcode = 2'b10; host_addr = 10'h0AA; host_wr_data = '0; host_miim_sel = 1'b1;
        host_req = 1'b1;
        for (int i = 0; i < 20 && !mif.mgmt_req; i++) tick();
        host_req = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("reset_mid_wait");
        flag = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            flag = flag | host_ack;
        end
        check("reset_no_ack", flag, 1'b0);
        for (int i = 0; i < 100 && resp_busy; i++) tick();
        tick();
        reg_data = 32'h5555_AAAA;
        host_txn(2'b10, 10'h240, 32'd0, 1'b0, {1'b0, 32'h5555_AAAA}, n0, tr, ta);
        check("post_reset_ack_lat", ta - n0, 3);
        repeat (3) tick();

        check("sb_empty", exp_grant.size() + exp_host.size() + exp_poll.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
